// File: rtl/coin_event_arbiter.sv
// coin_event_arbiter: edge-detects debounced coin buttons and queues them in round-robin order.
// It then feeds the vending FSM one rate-limited, single-cycle coin pulse at a time.
module coin_event_arbiter #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_nickel,
    input  logic                     req_dime,
    input  logic                     req_quarter,
    input  logic                     accept_en,
    input  logic                     flush,
    output logic                     btn_nickel,
    output logic                     btn_dime,
    output logic                     btn_quarter,
    output logic [2:0]               reject,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    // Coin codes: 0 = nickel, 1 = dime, 2 = quarter.
    function automatic logic [1:0] next_code(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    logic [2:0]    req_lvl;
    logic [2:0]    prev;
    logic [2:0]    edges;
    logic [1:0]    rr;
    logic [1:0]    rr_next;
    logic [3:0]    gap;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    mem [DEPTH];
    logic [CW-1:0] free;
    logic [CW-1:0] n_push;
    logic [1:0]    push_code [3];
    logic [2:0]    drop;
    logic          issue;
    logic [1:0]    head;
    logic [2:0]    pulse;

    assign req_lvl = {req_quarter, req_dime, req_nickel};
    assign edges   = req_lvl & ~prev;
    assign head    = mem[rd_ptr];
    assign issue   = accept_en & (q_count != '0) & (gap == 4'd0) & ~flush;

    // Walk the three codes starting at rr; edges past the pre-pop free space are dropped.
    always_comb begin
        logic [1:0] code;
        free    = CW'(DEPTH) - q_count;
        n_push  = '0;
        drop    = '0;
        rr_next = rr;
        code    = rr;
        for (int j = 0; j < 3; j++) begin
            push_code[j] = '0;
        end
        for (int j = 0; j < 3; j++) begin
            if (edges[code]) begin
                if (n_push < free) begin
                    push_code[n_push[1:0]] = code;
                    n_push                 = n_push + ONE;
                    rr_next                = next_code(code);
                end else begin
                    drop[code] = 1'b1;
                end
            end
            code = next_code(code);
        end
    end

    // btn_* and reject are one-cycle registered pulses; the FSM needs no handshake back.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= 3'b111;
            rr      <= 2'd0;
            gap     <= 4'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            pulse   <= '0;
            reject  <= '0;
        end else begin
            prev   <= req_lvl;
            pulse  <= '0;
            reject <= '0;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                q_count <= '0;
                gap     <= 4'd0;
            end else begin
                if (issue) begin
                    pulse[head] <= 1'b1;
                    rd_ptr      <= rd_ptr + PW'(1);
                    gap         <= 4'(GAP);
                end else if (gap != 4'd0) begin
                    gap <= gap - 4'd1;
                end
                wr_ptr  <= wr_ptr + PW'(n_push);
                q_count <= q_count + n_push - CW'(issue);
                reject  <= drop;
                rr      <= rr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int k = 0; k < 3; k++) begin
                if (CW'(k) < n_push) begin
                    mem[wr_ptr + PW'(k)] <= push_code[k];
                end
            end
        end
    end

    assign btn_nickel  = pulse[0];
    assign btn_dime    = pulse[1];
    assign btn_quarter = pulse[2];
    assign busy        = (q_count != '0) | (gap != 4'd0);

endmodule

// File: tb/tb_coin_event_arbiter.sv
// Bench for coin_event_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed pulse timing and order.
module tb_coin_event_arbiter;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_nickel = 1'b0, req_dime = 1'b0, req_quarter = 1'b0;
  logic accept_en = 1'b0, flush = 1'b0;
  logic btn_nickel, btn_dime, btn_quarter;
  logic [2:0] reject;
  logic [CW-1:0] q_count;
  logic busy;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  coin_event_arbiter #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_nickel(req_nickel), .req_dime(req_dime), .req_quarter(req_quarter),
    .accept_en(accept_en), .flush(flush),
    .btn_nickel(btn_nickel), .btn_dime(btn_dime), .btn_quarter(btn_quarter),
    .reject(reject), .q_count(q_count), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: coin queue, gap counter, round-robin start code
  logic [1:0] exp_q[$];
  int         m_gap = 0;
  int         m_rr = 0;
  logic [2:0] m_prev = 3'b111;
  logic [2:0] m_btn = 3'b000;
  logic [2:0] m_rej = 3'b000;
  bit         started = 0;
  logic [2:0] m_req, m_edge;
  int         m_room, m_last, m_c;
  bit         m_any;

  always @(posedge clk) begin
    started = 1;
    m_req = {req_quarter, req_dime, req_nickel};
    if (rst) begin
      exp_q.delete();
      m_gap = 0; m_rr = 0; m_prev = 3'b111; m_btn = 3'b000; m_rej = 3'b000;
    end else begin
      m_edge = m_req & ~m_prev;
      m_prev = m_req;
      m_btn = 3'b000;
      m_rej = 3'b000;
      if (flush) begin
        exp_q.delete();
        m_gap = 0;
      end else begin
        m_room = DEPTH - exp_q.size();
        if (accept_en && exp_q.size() != 0 && m_gap == 0) begin
          m_c = int'(exp_q.pop_front());
          m_btn[m_c] = 1'b1;
          m_gap = GAP;
        end else if (m_gap > 0) begin
          m_gap--;
        end
        m_any = 0;
        m_last = 0;
        for (int j = 0; j < 3; j++) begin
          m_c = (m_rr + j) % 3;
          if (m_edge[m_c]) begin
            if (m_room > 0) begin
              exp_q.push_back(2'(m_c));
              m_room--;
              m_last = m_c;
              m_any = 1;
            end else begin
              m_rej[m_c] = 1'b1;
            end
          end
        end
        if (m_any) m_rr = (m_last + 1) % 3;
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("btn", {29'd0, btn_quarter, btn_dime, btn_nickel}, {29'd0, m_btn});
      chk("reject", {29'd0, reject}, {29'd0, m_rej});
      chk("q_count", 32'(q_count), 32'(exp_q.size()));
      chk("busy", {31'd0, busy}, {31'd0, (exp_q.size() != 0 || m_gap != 0)});
    end
  end

  // record observed pulse order
  logic [1:0] obs_q[$];
  always @(negedge clk) begin
    if (started) begin
      case ({btn_quarter, btn_dime, btn_nickel})
        3'b000: ;
        3'b001: obs_q.push_back(2'd0);
        3'b010: obs_q.push_back(2'd1);
        3'b100: obs_q.push_back(2'd2);
        default: obs_q.push_back(2'd3);
      endcase
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] r);
    {req_quarter, req_dime, req_nickel} = r;
  endtask

  task automatic press(input int code);
    logic [2:0] r;
    r = 3'b000;
    r[code] = 1'b1;
    set_req(r);
    tick(1);
    set_req(3'b000);
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(3'b000);
    accept_en = 1'b0;
    flush = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  logic [2:0] seq [8];

  initial begin
    // reset values
    tick(2);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_reject", {29'd0, reject}, 32'd0);
    chk("rst_btn", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'd0);
    rst = 1'b0;
    tick(1);

    // single dime: 2-cycle press-to-pulse, one-cycle pulse
    accept_en = 1'b1;
    set_req(3'b010);
    tick(1);
    chk("dime_qc1", 32'(q_count), 32'd1);
    chk("dime_btn_early", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'd0);
    tick(1);
    chk("dime_btn", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'b010);
    chk("dime_qc0", 32'(q_count), 32'd0);
    tick(1);
    chk("dime_btn_off", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'd0);
    set_req(3'b000);
    tick(3);

    // rr now at quarter: nickel+quarter together go quarter first, rr -> dime
    obs_q.delete();
    set_req(3'b101);
    tick(1);
    chk("rr_model", 32'(m_rr), 32'd1);
    chk("rr_qc", 32'(q_count), 32'd2);
    tick(1);
    chk("rr_first_quarter", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'b100);
    set_req(3'b000);
    tick(8);
    chk("rr_obs_n", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      chk("rr_obs0", {30'd0, obs_q[0]}, 32'd2);
      chk("rr_obs1", {30'd0, obs_q[1]}, 32'd0);
    end

    // simultaneous press from rr=0: nickel, dime, quarter 3 cycles apart
    do_reset();
    accept_en = 1'b1;
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b000; seq[3] = 3'b000;
    seq[4] = 3'b010; seq[5] = 3'b000; seq[6] = 3'b000; seq[7] = 3'b100;
    set_req(3'b111);
    tick(1);
    chk("sim_qc", 32'(q_count), 32'd3);
    chk("sim_rr_model", 32'(m_rr), 32'd0);
    set_req(3'b000);
    for (int k = 1; k < 8; k++) begin
      tick(1);
      chk($sformatf("sim_btn_%0d", k), {29'd0, btn_quarter, btn_dime, btn_nickel}, {29'd0, seq[k]});
    end
    tick(3);

    // overflow with accept_en low, then drain in order
    do_reset();
    obs_q.delete();
    press(0); press(1); press(2); press(0);
    chk("ovf_qc4", 32'(q_count), 32'd4);
    set_req(3'b100);
    tick(1);
    chk("ovf_reject", {29'd0, reject}, 32'b100);
    chk("ovf_qc_hold", 32'(q_count), 32'd4);
    set_req(3'b000);
    tick(1);
    chk("ovf_reject_off", {29'd0, reject}, 32'd0);
    chk("ovf_no_pulse", 32'(obs_q.size()), 32'd0);
    accept_en = 1'b1;
    tick(14);
    chk("ovf_drain_n", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      chk("ovf_d0", {30'd0, obs_q[0]}, 32'd0);
      chk("ovf_d1", {30'd0, obs_q[1]}, 32'd1);
      chk("ovf_d2", {30'd0, obs_q[2]}, 32'd2);
      chk("ovf_d3", {30'd0, obs_q[3]}, 32'd0);
    end
    chk("ovf_idle", {31'd0, busy}, 32'd0);

    // full queue: a same-cycle pop does not make room
    do_reset();
    press(0); press(1); press(2); press(0);
    accept_en = 1'b1;
    set_req(3'b100);
    tick(1);
    chk("popfull_reject", {29'd0, reject}, 32'b100);
    chk("popfull_qc", 32'(q_count), 32'd3);
    chk("popfull_btn", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'b001);
    set_req(3'b000);
    accept_en = 1'b0;
    tick(2);

    // flush with a same-cycle nickel edge
    do_reset();
    press(0); press(1); press(2);
    chk("fl_qc3", 32'(q_count), 32'd3);
    flush = 1'b1;
    set_req(3'b001);
    tick(1);
    chk("fl_qc0", 32'(q_count), 32'd0);
    chk("fl_reject", {29'd0, reject}, 32'd0);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    tick(1);
    chk("fl_held_no_edge", 32'(q_count), 32'd0);
    set_req(3'b000);
    tick(2);

    // quarter held through reset is not counted; re-press gives one pulse
    rst = 1'b1;
    set_req(3'b100);
    accept_en = 1'b1;
    tick(2);
    rst = 1'b0;
    obs_q.delete();
    tick(4);
    chk("held_qc", 32'(q_count), 32'd0);
    chk("held_no_pulse", 32'(obs_q.size()), 32'd0);
    set_req(3'b000);
    tick(1);
    set_req(3'b100);
    tick(1);
    set_req(3'b000);
    tick(5);
    chk("held_one_pulse", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) chk("held_code", {30'd0, obs_q[0]}, 32'd2);

    // accept_en dropped mid-gap: gap still counts, re-raise issues at once
    do_reset();
    press(0); press(1); press(2);
    accept_en = 1'b1;
    tick(1);
    chk("gate_first", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'b001);
    chk("gate_qc2", 32'(q_count), 32'd2);
    accept_en = 1'b0;
    tick(3);
    chk("gate_hold_qc", 32'(q_count), 32'd2);
    chk("gate_hold_busy", {31'd0, busy}, 32'd1);
    accept_en = 1'b1;
    tick(1);
    chk("gate_reissue", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'b010);
    chk("gate_qc1", 32'(q_count), 32'd1);
    tick(6);
    chk("gate_drained", 32'(q_count), 32'd0);

    // reset mid-operation clears queue and any pulse
    press(0); press(1);
    rst = 1'b1;
    tick(1);
    chk("midrst_qc", 32'(q_count), 32'd0);
    chk("midrst_btn", {29'd0, btn_quarter, btn_dime, btn_nickel}, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_event_arbiter.md
# coin_event_arbiter

Sits between the debounced coin buttons and the vending FSM's `btn_nickel`/`btn_dime`/`btn_quarter` inputs. The FSM accepts at most one coin per cycle and silently ignores simultaneous presses; this block makes coin entry lossless and ordered. It edge-detects button levels, queues coin events in a small FIFO with round-robin ordering for same-cycle presses, and reports overflow drops. It issues one single-cycle coin pulse at a time, rate-limited, only while the FSM is accepting coins.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of 2, 2..16.
- `GAP`, default 2: idle cycles forced after each issued pulse. Range 0..15.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_nickel`  in  1  debounced nickel button level
- `req_dime`  in  1  debounced dime button level
- `req_quarter`  in  1  debounced quarter button level
- `accept_en`  in  1  high while the FSM is in its coin-insert state
- `flush`  in  1  discard all queued coins, e.g. on leaving the insert state
- `btn_nickel`  out  1  registered one-cycle nickel pulse to the FSM
- `btn_dime`  out  1  registered one-cycle dime pulse
- `btn_quarter`  out  1  registered one-cycle quarter pulse
- `reject`  out  3  registered one-cycle drop flags {quarter, dime, nickel}
- `q_count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `busy`  out  1  `q_count != 0` or gap counter `!= 0`

## Operation
- Coin codes: nickel=0, dime=1, quarter=2. FIFO entries are 2 bits.
- **Edge detect:** `prev[2:0]` holds last-sampled levels. `edge[i] = req[i] & ~prev[i]`. `prev` resets to 3'b111, so a button held through reset is not counted.
- **Enqueue order:**
  - Round-robin pointer `rr` (reset 0) gives the write order for same-cycle edges: `rr`, `rr+1`, `rr+2` (mod 3), asserted edges only.
  - After any cycle with at least one enqueue, `rr` moves to the code following the last enqueued code.
- **Capacity:**
  - `free = DEPTH - q_count`, using the pre-pop count. A same-cycle pop does not create room.
  - Edges in write order beyond `free` are dropped. The matching `reject` bit pulses the next cycle.
- **Issue:**
  - Condition: `accept_en & (q_count != 0) & (gap == 0) & ~flush`.
  - Pops the head entry. The one-hot `btn_*` for that code is high for exactly the next cycle.
  - Loads `gap = GAP`. `gap` decrements by 1 per cycle while nonzero, independent of `accept_en`.
- **accept_en low:** nothing is issued. The queue holds and enqueue continues.
- **Flush:**
  - Empties the FIFO and ignores same-cycle edges; no `reject` for them.
  - Clears `gap`. `prev` still updates. `rr` is unchanged.
  - Flush has priority over issue and enqueue.
- **Occupancy:** `q_count` update = `+ accepted pushes - pop`. It never exceeds `DEPTH`.

## Timing
- **Reset values:**
  - All `btn_*` = 0, `reject` = 0, `q_count` = 0, `busy` = 0.
  - `gap` = 0, `rr` = 0, `prev` = 3'b111, FIFO pointers = 0.
- **Latency:**
  - An edge sampled at posedge N, with an empty queue, `accept_en` high and `gap` 0, is enqueued at N.
  - That entry is issued at N+1, and `btn_*` is high during cycle N+1..N+2.
  - Minimum press-to-pulse latency is therefore 2 cycles.
- **Spacing:** an issue at posedge N means the next issue is no earlier than posedge N+GAP+1. With `GAP=2`, pulses are 3 cycles apart. With `GAP=0`, pulses can be back-to-back.
- **Reset mid-operation:** queued coins are lost. A pulse in flight is cleared at the reset edge.
- **Pointer wrap:** FIFO read/write pointers wrap mod `DEPTH`. Full vs empty is resolved by `q_count`.

## Test plan
- **Single dime:** `accept_en=1`, rise `req_dime` at cycle 5 → `btn_dime` high in cycle 7 only; `q_count` goes 1 then 0.
- **Simultaneous press:** all three requests rise together with `rr=0` → pulses nickel, dime, quarter, 3 cycles apart (`GAP=2`); `rr` ends at 0.
- **Overflow:** `DEPTH=4`, `accept_en=0`, 4 separate presses, then a 5th quarter → `q_count=4`, `reject=3'b100` for one cycle, no `btn_*`. Raising `accept_en` then yields 4 pulses.
- **Flush:** 3 queued coins, `flush` pulse in the same cycle as a nickel edge → `q_count=0`, no pulses, no `reject`, `busy=0` next cycle.
- **Held button across reset:** `req_quarter=1` through reset release → no enqueue. Release then re-press → exactly one quarter pulse.
- **accept_en gating:** `accept_en` drops mid-gap with 2 queued → gap still counts down. Re-raising `accept_en` issues immediately if `gap` is 0.
